// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes and status out.
// master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       IFID_rs;
    logic [4:0]       IFID_rt;
    logic [4:0]       IDEX_rt;
    logic             IDEX_memRead;
    logic             IDEX_mduStart;
    logic             IFID_mduUse;
    logic             EX_branchTaken;
    logic             EXMEM_memAccess;
    logic             dmem_ready;
    logic             pcWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             EXMEMWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             MEMWBFlush;
    logic             mduBusy;
    logic             memFault;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output IFID_rs, IFID_rt, IDEX_rt, IDEX_memRead, IDEX_mduStart, IFID_mduUse,
               EX_branchTaken, EXMEM_memAccess, dmem_ready,
        input  pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush,
               mduBusy, memFault, stallCycles
    );

    modport slave (
        input  IFID_rs, IFID_rt, IDEX_rt, IDEX_memRead, IDEX_mduStart, IFID_mduUse,
               EX_branchTaken, EXMEM_memAccess, dmem_ready,
        output pcWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush,
               mduBusy, memFault, stallCycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing control for the 5-stage MIPS datapath: load-use stalls, branch flushes,
// MULT/DIV occupancy and data-memory wait states with a sticky timeout fault.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {StRun, StMduBusy} state_e;

    state_e           state_q;
    logic [7:0]       mdu_cnt_q;
    logic [7:0]       mem_cnt_q;
    logic [7:0]       mem_cnt_inc;
    logic             mem_fault_q;
    logic [CNT_W-1:0] stall_q;

    logic freeze, load_use, mdu_stall;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, memwb_flush;

    assign freeze    = hz.EXMEM_memAccess & ~hz.dmem_ready;
    assign load_use  = hz.IDEX_memRead & (hz.IDEX_rt != 5'd0) &
                       ((hz.IDEX_rt == hz.IFID_rs) | (hz.IDEX_rt == hz.IFID_rt));
    assign mdu_stall = (state_q == StMduBusy) & hz.IFID_mduUse;

    assign mem_cnt_inc = (mem_cnt_q == 8'hFF) ? 8'hFF : mem_cnt_q + 8'd1;

    // A freeze holds every stage in place, so lower-priority hazards are simply re-seen next cycle.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (hz.EX_branchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use | mdu_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            mdu_cnt_q   <= 8'd0;
            mem_cnt_q   <= 8'd0;
            mem_fault_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            // The MDU counts down regardless of freezes or branches once it owns an op.
            case (state_q)
                StRun: begin
                    if (hz.IDEX_mduStart & ~freeze) begin
                        state_q   <= StMduBusy;
                        mdu_cnt_q <= 8'(MDU_LATENCY - 1);
                    end
                end
                StMduBusy: begin
                    if (mdu_cnt_q == 8'd0) begin
                        state_q <= StRun;
                    end else begin
                        mdu_cnt_q <= mdu_cnt_q - 8'd1;
                    end
                end
                default: state_q <= StRun;
            endcase

            if (freeze) begin
                mem_cnt_q <= mem_cnt_inc;
                if (mem_cnt_inc >= 8'(MEM_TIMEOUT)) begin
                    mem_fault_q <= 1'b1;
                end
            end else begin
                mem_cnt_q <= 8'd0;
            end

            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign hz.pcWrite     = pc_write;
    assign hz.IFIDWrite   = ifid_write;
    assign hz.IDEXWrite   = idex_write;
    assign hz.EXMEMWrite  = exmem_write;
    assign hz.IFIDFlush   = ifid_flush;
    assign hz.IDEXFlush   = idex_flush;
    assign hz.MEMWBFlush  = memwb_flush;
    assign hz.mduBusy     = (state_q == StMduBusy);
    assign hz.memFault    = mem_fault_q;
    assign hz.stallCycles = stall_q;
endmodule
